// File: rtl/lif_neuron_update.sv
// lif_neuron_update: pipelined read-modify-write engine for leaky integrate-and-fire
// membrane potentials. Events (address, current) are accepted in stage 0, the membrane
// RAM read returns in stage S1 where leak, integration and threshold/reset are applied,
// S2 drives the RAM write port, and S3 remembers the last write so back-to-back events
// to one neuron see the newest potential. Spiking addresses go out through a 2-entry FIFO.
// Optional feature macro: LIF_SAT_EN (saturate v_new instead of two's complement wrap).
module lif_neuron_update #(
    parameter int                           DATA_WIDTH = 24,
    parameter int                           ADDR_WIDTH = 10,
    parameter int                           LEAK_SHIFT = 4,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD  = 24'sh001000,
    parameter logic signed [DATA_WIDTH-1:0] V_RESET    = 24'sh000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_current,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  spk_valid,
    input  logic                  spk_ready,
    output logic [ADDR_WIDTH-1:0] spk_addr,
    output logic                  busy
);

    localparam int SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    // Pipeline state
    logic                  s1_valid_q, s2_valid_q, s3_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q, s3_addr_q;
    logic [DATA_WIDTH-1:0] s1_cur_q, s2_data_q, s3_data_q;

    // Spike FIFO state
    logic [ADDR_WIDTH-1:0] fifo_q [0:1];
    logic                  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    // Datapath signals
    logic                         accept_s, push_s, pop_s, spike_s;
    logic signed [DATA_WIDTH-1:0] v_old_s, leak_s, v_new_s;
    logic signed [SW-1:0]         sum_s;
    logic [DATA_WIDTH-1:0]        wb_data_s;

    // Ready leaves a FIFO slot for every event that may still spike
    assign in_ready    = (({1'b0, count_q} + {2'b00, s1_valid_q}) < 3'd2);
    assign accept_s    = in_valid & in_ready;
    assign mem_rd_en   = accept_s;
    assign mem_rd_addr = in_addr;

    assign mem_wr_en   = s2_valid_q;
    assign mem_wr_addr = s2_addr_q;
    assign mem_wr_data = s2_data_q;

    assign spk_valid   = (count_q != 2'd0);
    assign spk_addr    = fifo_q[rd_ptr_q];
    assign pop_s       = spk_valid & spk_ready;
    assign push_s      = s1_valid_q & spike_s;

    assign busy        = s1_valid_q | s2_valid_q | s3_valid_q | spk_valid;

    // S1 operand select: newest in-flight write wins over the RAM read data
    always_comb begin
        v_old_s = $signed(mem_rd_data);
        if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
            v_old_s = $signed(s2_data_q);
        end else if (s3_valid_q && (s3_addr_q == s1_addr_q)) begin
            v_old_s = $signed(s3_data_q);
        end else begin
            v_old_s = $signed(mem_rd_data);
        end
    end

    // S1 leak, integrate, width-reduce and threshold
    always_comb begin
        leak_s  = v_old_s >>> LEAK_SHIFT;
        sum_s   = SW'(v_old_s) - SW'(leak_s) + SW'($signed(s1_cur_q));
        v_new_s = sum_s[DATA_WIDTH-1:0];
`ifdef LIF_SAT_EN
        if (sum_s > SAT_MAX) begin
            v_new_s = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum_s < SAT_MIN) begin
            v_new_s = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            v_new_s = sum_s[DATA_WIDTH-1:0];
        end
`else
        v_new_s = sum_s[DATA_WIDTH-1:0];
`endif
        spike_s = (v_new_s >= THRESHOLD);
        if (spike_s) begin
            wb_data_s = V_RESET;
        end else begin
            wb_data_s = v_new_s;
        end
    end

    // Spike FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + 2'd1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Pipeline stages and spike FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            s3_addr_q  <= '0;
            s1_cur_q   <= '0;
            s2_data_q  <= '0;
            s3_data_q  <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_addr_q <= in_addr;
                s1_cur_q  <= in_current;
            end
            s2_valid_q <= s1_valid_q;
            s2_addr_q  <= s1_addr_q;
            s2_data_q  <= wb_data_s;
            s3_valid_q <= s2_valid_q;
            s3_addr_q  <= s2_addr_q;
            s3_data_q  <= s2_data_q;
            if (push_s) begin
                fifo_q[wr_ptr_q] <= s1_addr_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_lif_neuron_update.sv
// Self-checking bench for lif_neuron_update: a synchronous RAM model plus a
// transaction-level reference (golden potentials, expected write and spike queues).
module tb_lif_neuron_update;
    localparam int DW = 24;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, mem_rd_en, mem_wr_en, spk_valid, spk_ready, busy;
    logic [AW-1:0] in_addr, mem_rd_addr, mem_wr_addr, spk_addr;
    logic [DW-1:0] in_current, mem_rd_data, mem_wr_data;

    always #5 clk = ~clk;

    lif_neuron_update dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_current(in_current), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .spk_valid(spk_valid),
        .spk_ready(spk_ready), .spk_addr(spk_addr), .busy(busy)
    );

    // Membrane RAM: read returns old data when read and write hit the same edge
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pre_en, clr;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_val;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
        end else begin
            if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
            if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
            if (pre_en) ram[pre_addr] <= pre_val;
        end
    end

    typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int due; logic [AW-1:0] addr; } sp_t;
    wr_t           wq[$];
    sp_t           pq[$];
    logic [AW-1:0] vis[$];
    logic [DW-1:0] ref_v [0:(1<<AW)-1];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic          h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic [DW-1:0] last_wr_data;
    logic [AW-1:0] last_wr_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference neuron update from the plain arithmetic rules
    function automatic logic [DW-1:0] model_v(input logic [DW-1:0] old, input logic [DW-1:0] cur,
                                              output logic spk);
        longint vo, c, lk, s, vn;
        vo = longint'($signed(old));
        c  = longint'($signed(cur));
        lk = (vo >= 0) ? (vo / 16) : -((-vo + 15) / 16);
        s  = vo - lk + c;
`ifdef LIF_SAT_EN
        if (s > 64'sd8388607) vn = 64'sd8388607;
        else if (s < -64'sd8388608) vn = -64'sd8388608;
        else vn = s;
`else
        vn = ((s % 64'sd16777216) + 64'sd16777216) % 64'sd16777216;
        if (vn >= 64'sd8388608) vn = vn - 64'sd16777216;
`endif
        spk = (vn >= 64'sd4096);
        return spk ? 24'h000000 : vn[DW-1:0];
    endfunction

    // One clock: check outputs at the falling edge, then drive the next inputs
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] cur,
                         input logic rdy);
        logic exp_wr, acc, pop, sp;
        logic [DW-1:0] nv;
        wr_t w;
        sp_t s;
        @(negedge clk);
        cyc++;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            s = pq.pop_front();
            vis.push_back(s.addr);
        end
        exp_wr = (wq.size() > 0) && (wq[0].due == cyc);
        chk("wr_en", {31'd0, mem_wr_en}, {31'd0, exp_wr});
        if (exp_wr) begin
            w = wq.pop_front();
            chk("wr_addr", {22'd0, mem_wr_addr}, {22'd0, w.addr});
            chk("wr_data", {8'd0, mem_wr_data}, {8'd0, w.data});
        end
        if (mem_wr_en) begin
            last_wr_data = mem_wr_data;
            last_wr_addr = mem_wr_addr;
        end
        chk("spk_valid", {31'd0, spk_valid}, {31'd0, vis.size() > 0});
        if (vis.size() > 0) chk("spk_addr", {22'd0, spk_addr}, {22'd0, vis[0]});
        chk("busy", {31'd0, busy}, {31'd0, (h1 | h2 | h3 | (vis.size() > 0))});
        chk("in_ready", {31'd0, in_ready}, {31'd0, ((vis.size() + int'(h1)) < 2)});
        in_valid = v; in_addr = a; in_current = cur; spk_ready = rdy;
        #1;
        chk("rd_en", {31'd0, mem_rd_en}, {31'd0, v & in_ready});
        acc = v & in_ready;
        pop = spk_valid & rdy;
        if (pop && vis.size() > 0) void'(vis.pop_front());
        if (acc) begin
            nv = model_v(ref_v[a], cur, sp);
            ref_v[a] = nv;
            wq.push_back('{cyc + 2, a, nv});
            if (sp) pq.push_back('{cyc + 2, a});
        end
        h3 = h2; h2 = h1; h1 = acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pre_en = 1'b1; pre_addr = a; pre_val = v; ref_v[a] = v;
        idle(1);
        pre_en = 1'b0;
    endtask

    initial begin
        logic sp;
        logic [DW-1:0] r, c;
        rst_n = 1'b0; clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_val = '0;
        in_valid = 1'b0; in_addr = '0; in_current = '0; spk_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_v[i] = '0;
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_spk_valid", {31'd0, spk_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Hand-computed values pin the reference model
        r = model_v(24'd0, 24'd100, sp);     chk("m_100", {8'd0, r}, 32'd100);
        r = model_v(24'd100, 24'd100, sp);   chk("m_194", {8'd0, r}, 32'd194);
        r = model_v(24'd1000, 24'd1000, sp); chk("m_1938", {8'd0, r}, 32'd1938);
        r = model_v(24'd1938, 24'd1000, sp); chk("m_2817", {8'd0, r}, 32'd2817);
        r = model_v(24'd4000, 24'd200, sp);  chk("m_3950", {8'd0, r, 7'd0, sp}, {8'd0, 24'd3950, 8'd0});
        r = model_v(24'd4000, 24'd400, sp);  chk("m_spike", {8'd0, r, 7'd0, sp}, {32'd0, 8'd1} >> 8 | 32'd1);
        r = model_v(24'h800100, 24'hC00000, sp);
`ifdef LIF_SAT_EN
        chk("m_sat", {7'd0, sp, r}, {8'd0, 24'h800000});
`else
        chk("m_wrap", {7'd0, sp, r}, {8'd1, 24'h000000});
`endif

        // Directed: integrate, forwarding, threshold
        idle(2);
        cycle(1'b1, 10'd5, 24'd100, 1'b1); idle(4);
        chk("t1_first", {8'd0, last_wr_data}, 32'd100);
        cycle(1'b1, 10'd5, 24'd100, 1'b1); idle(4);
        chk("t1_second", {8'd0, last_wr_data}, 32'd194);
        for (int i = 0; i < 3; i++) cycle(1'b1, 10'd7, 24'd1000, 1'b1);
        idle(4);
        chk("t2_third", {8'd0, last_wr_data}, 32'd2817);
        preload(10'd9, 24'd4000);
        cycle(1'b1, 10'd9, 24'd200, 1'b1); idle(4);
        chk("t3_nospike", {8'd0, last_wr_data}, 32'd3950);
        preload(10'd9, 24'd4000);
        cycle(1'b1, 10'd9, 24'd400, 1'b1); idle(4);
        chk("t3_reset", {8'd0, last_wr_data}, 32'd0);

        // Directed: FIFO fill stalls input, drain restores it
        preload(10'd1, 24'd4000);
        preload(10'd2, 24'd4000);
        cycle(1'b1, 10'd1, 24'd400, 1'b0);
        cycle(1'b1, 10'd2, 24'd400, 1'b0);
        cycle(1'b0, 10'd0, 24'd0, 1'b0);
        chk("t4_stall", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 24'd0, 1'b0);
        idle(3);
        chk("t4_resume", {31'd0, in_ready}, 32'd1);

        // Directed: wrap or saturate on a large negative current
        preload(10'd3, 24'h800100);
        cycle(1'b1, 10'd3, 24'hC00000, 1'b1); idle(4);
`ifdef LIF_SAT_EN
        chk("t5_sat", {8'd0, last_wr_data}, 32'h800000);
`else
        chk("t5_wrap", {8'd0, last_wr_data}, 32'h000000);
`endif

        // Randomized traffic on a few neurons to stress forwarding and backpressure
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) c = 24'($urandom);
            else c = 24'(int'($urandom_range(0, 3000)) - 1000);
            cycle($urandom_range(0, 3) != 0, 10'($urandom_range(0, 7)), c,
                  $urandom_range(0, 2) != 0);
        end
        idle(6);

        // Asynchronous reset with work in flight
        preload(10'd20, 24'd4000);
        cycle(1'b1, 10'd20, 24'd400, 1'b0);
        cycle(1'b1, 10'd21, 24'd5, 1'b0);
        cycle(1'b1, 10'd22, 24'd5, 1'b0);
        cycle(1'b0, 10'd0, 24'd0, 1'b0);
        chk("t6_pre_busy", {31'd0, busy}, 32'd1);
        chk("t6_pre_spk", {31'd0, spk_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("t6_spk_valid", {31'd0, spk_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        wq.delete(); pq.delete(); vis.delete();
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_v[i] = ram[i];
        preload(10'd5, 24'd0);
        cycle(1'b1, 10'd5, 24'd10, 1'b1); idle(4);
        chk("t6_after", {8'd0, last_wr_data}, 32'd10);
        chk("t6_after_addr", {22'd0, last_wr_addr}, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
